booth_mul_seq: RTL and testbench

Multi-cycle controller that sequences a signed radix-4 Booth multiply. It retires one Booth digit per clock and reuses a single partial-product selector plus a 2N-bit accumulator, instead of a combinational adder chain. It sits between the CPU execute stage and the register file, replacing the loop-based multiplier, and uses a start/busy/done handshake.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_pp_sel.sv | 18 +
 rtl/booth_mul_seq.sv | 92 +++++++++
 tb/tb_booth_mul_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types, triplet codes and width helpers for the radix-4 Booth sequencer.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] TRI_P1A = 3'b001;
    localparam logic [2:0] TRI_P1B = 3'b010;
    localparam logic [2:0] TRI_P2  = 3'b011;
    localparam logic [2:0] TRI_M2  = 3'b100;
    localparam logic [2:0] TRI_M1A = 3'b101;
    localparam logic [2:0] TRI_M1B = 3'b110;

    function automatic int cnt_w(input int n);
        return (n / 2 > 1) ? $clog2(n / 2) : 1;
    endfunction

    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: maps one Booth triplet to the unshifted partial product 0, +-M or +-2M.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [2:0]   trip,
    input  logic [W-1:0] msx,
    output logic [W-1:0] pp
);

    always_comb
        pp = (trip == TRI_P1A || trip == TRI_P1B) ? msx :
             (trip == TRI_P2)                     ? msx << 1 :
             (trip == TRI_M2)                     ? -(msx << 1) :
             (trip == TRI_M1A || trip == TRI_M1B) ? -msx : '0;

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed radix-4 Booth multiplier, one digit per clock.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N-1:0]         M,
    input  logic [N-1:0]         Q,
    output logic                 busy,
    output logic                 done,
    output logic [prod_w(N)-1:0] P
);

    localparam int PW = prod_w(N);
    localparam int CW = cnt_w(N);

    state_t        state_q, state_d;
    logic [PW-1:0] msx_q, msx_d, acc_q, acc_d, p_q, p_d, pp, acc_nxt;
    logic [N:0]    qs_q, qs_d, qs_sh;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    booth_pp_sel #(.W(PW)) u_sel (
        .trip (qs_q[2:0]),
        .msx  (msx_q),
        .pp   (pp)
    );

    always_comb begin
        state_d = state_q;
        msx_d   = msx_q;
        qs_d    = qs_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        acc_nxt = acc_q + (pp << (2 * cnt_q));
        qs_sh   = {qs_q[N], qs_q[N], qs_q[N:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // A sign-only remainder yields nothing but zero digits from here on.
        last    = (cnt_q == CW'(N / 2 - 1)) || (&qs_sh) || !(|qs_sh);
`else
        last    = cnt_q == CW'(N / 2 - 1);
`endif
        case (state_q)
            IDLE: if (start) begin
                msx_d   = {{N{M[N-1]}}, M};
                qs_d    = {Q, 1'b0};
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_nxt;
                qs_d  = qs_sh;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    p_d     = acc_nxt;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            msx_q   <= '0;
            qs_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            msx_q   <= msx_d;
            qs_q    <= qs_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign P    = p_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq against a plain-arithmetic product model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] M = '0;
    logic [31:0] Q = '0;
    logic        busy, done;
    logic [63:0] P;
    int          vectors = 0;
    int          miscompares = 0;

    booth_mul_seq #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .M     (M),
        .Q     (Q),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] a, b;
        a = {{32{m[31]}}, m};
        b = {{32{q[31]}}, q};
        return a * b;
    endfunction

    function automatic int ref_lat(input logic [31:0] q);
`ifdef BOOTH_EARLY_TERM_EN
        logic signed [31:0] r;
        for (int k = 1; k <= 16; k++) begin
            r = $signed(q) >>> (2 * k - 1);
            if (r == 0 || r == -1) return k;
        end
`endif
        return 16;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        @(negedge clk);
        M = m;
        Q = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        M = $urandom;
        Q = $urandom;
    endtask

    // Called at the negedge right after the accepting edge; returns in the following IDLE cycle.
    task automatic wait_done(input string tag, input logic [63:0] exp_p, input int exp_lat);
        int busy_n = 0, done_n = 0, lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_n), 64'(exp_lat + 1));
        chk({tag, "_done"}, 64'(done_n), 64'd1);
        chk({tag, "_p"}, P, exp_p);
    endtask

    task automatic mul(input string tag, input logic [31:0] m, input logic [31:0] q);
        launch(m, q);
        wait_done(tag, ref_mul(m, q), ref_lat(q));
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_p", P, 64'd0);

        mul("m3q5", 32'd3, 32'd5);
        chk("m3q5_const", P, 64'd15);
        mul("mn7q6", 32'hFFFF_FFF9, 32'd6);
        chk("mn7q6_const", P, 64'hFFFF_FFFF_FFFF_FFD6);
        mul("m6qn7", 32'd6, 32'hFFFF_FFF9);
        chk("m6qn7_const", P, 64'hFFFF_FFFF_FFFF_FFD6);
        mul("minmin", 32'h8000_0000, 32'h8000_0000);
        chk("minmin_const", P, 64'h4000_0000_0000_0000);
        mul("maxmin", 32'h7FFF_FFFF, 32'h8000_0000);
        chk("maxmin_const", P, 64'hC000_0000_8000_0000);
        mul("q0", 32'h1234_5678, 32'd0);
        mul("q2", 32'h0000_0321, 32'd2);
        mul("qn1", 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Extra starts during RUN and DONE must be dropped; the IDLE start after DONE is taken.
        launch(32'd1000, 32'hFFFF_FF00);
        repeat (4) @(negedge clk);
        M = 32'd77;
        Q = 32'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        chk("ign_done_seen", 64'(done), 64'd1);
        chk("ign_p_done", P, ref_mul(32'd1000, 32'hFFFF_FF00));
        M = 32'd55;
        Q = 32'd44;
        start = 1'b1;
        @(negedge clk);
        chk("ign_idle_busy", 64'(busy), 64'd0);
        chk("ign_p_idle", P, ref_mul(32'd1000, 32'hFFFF_FF00));
        @(negedge clk);
        start = 1'b0;
        wait_done("accept", ref_mul(32'd55, 32'd44), ref_lat(32'd44));

        // Reset mid-run discards the in-flight product.
        launch(32'd9, 32'd9);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_p", P, 64'd0);
        mul("m12q12", 32'd12, 32'd12);
        chk("m12q12_const", P, 64'd144);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(0, 15));
            if (i % 4 == 3) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            mul("rand", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
